// File: rtl/cpu_sequencer_pkg.sv
// Shared encodings for the rv32i multi-cycle sequencer: FSM states,
// decoder instruction classes and small class-decoding helpers.
package cpu_sequencer_pkg;

   typedef enum logic [2:0] {
      ST_INIT    = 3'd0,
      ST_INIT_PC = 3'd1,   // also serves as PCUPD when force_zero is low
      ST_FETCH   = 3'd2,
      ST_DECODE  = 3'd3,
      ST_EXEC    = 3'd4,
      ST_MEM     = 3'd5,
      ST_WB      = 3'd6,
      ST_HALT    = 3'd7
   } state_e;

   localparam logic [2:0] CLASS_ALU     = 3'd0;
   localparam logic [2:0] CLASS_LOAD    = 3'd1;
   localparam logic [2:0] CLASS_STORE   = 3'd2;
   localparam logic [2:0] CLASS_BRANCH  = 3'd3;
   localparam logic [2:0] CLASS_JUMP    = 3'd4;
   localparam logic [2:0] CLASS_SYSTEM  = 3'd5;
   localparam logic [2:0] CLASS_ILLEGAL = 3'd6;   // 7 is illegal as well

   // Codes 6 and 7 are both treated as illegal instructions.
   function automatic logic class_is_illegal(input logic [2:0] cls);
      return cls[2] & cls[1];
   endfunction

   // Classes that need a data-memory access between EXEC and WB.
   function automatic logic class_is_mem(input logic [2:0] cls);
      return (cls == CLASS_LOAD) || (cls == CLASS_STORE);
   endfunction

   // Classes that write a result (or link address) into the register file.
   function automatic logic class_writes_rf(input logic [2:0] cls);
      return (cls == CLASS_ALU) || (cls == CLASS_LOAD) || (cls == CLASS_JUMP);
   endfunction

endpackage

// File: rtl/cpu_sequencer_retire_counter.sv
// Retired-instruction counter; wraps modulo 2^DATA_WIDTH.
module retire_counter #(
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  inc,
   output logic [DATA_WIDTH-1:0] count
);

   logic [DATA_WIDTH-1:0] count_q;
   logic [DATA_WIDTH-1:0] count_d;

   // Next count: advance by one on each retire strobe.
   always_comb begin
      // NOTE: count_d is assigned on every path, so no latch is inferred.
      count_d = count_q;
      if (inc) begin
         count_d = count_q + DATA_WIDTH'(1);
      end
   end

   // Count register with synchronous clear.
   always_ff @(posedge clk) begin
      // NOTE: flops use non-blocking assignments so every register sees pre-edge values.
      if (reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count = count_q;

endmodule

// File: rtl/cpu_sequencer.sv
// Multi-cycle control FSM for the rv32i core: sequences fetch, decode,
// execute, memory and write-back, drives the imem/dmem handshakes and
// issues exactly one update_pc strobe per retired instruction.
module cpu_sequencer
   import cpu_sequencer_pkg::*;
#(
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  run,
   output logic                  imem_req,
   input  logic                  imem_ack,
   output logic                  ir_load,
   input  logic [2:0]            instr_class,
   output logic                  dmem_req,
   output logic                  dmem_we,
   input  logic                  dmem_ack,
   output logic                  rf_we,
   output logic                  force_zero,
   output logic                  update_pc,
   output logic                  halted,
   output logic                  illegal,
   output logic [DATA_WIDTH-1:0] instret,
   output logic [2:0]            state
);

   state_e     state_q;
   logic [2:0] class_q;
   logic       imem_req_q;
   logic       dmem_req_q;
   logic       dmem_we_q;
   logic       rf_we_q;
   logic       force_zero_q;
   logic       update_pc_q;
   logic       halted_q;
   logic       illegal_q;

   // Sequencer FSM; every control output is a flop set on the transition into its state.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= ST_INIT;
         class_q      <= CLASS_ALU;
         imem_req_q   <= 1'b0;
         dmem_req_q   <= 1'b0;
         dmem_we_q    <= 1'b0;
         rf_we_q      <= 1'b0;
         force_zero_q <= 1'b1;
         update_pc_q  <= 1'b0;
         halted_q     <= 1'b0;
         illegal_q    <= 1'b0;
      end else begin
         case (state_q)
            ST_INIT: begin
               // Load PC with zero on the next strobe.
               force_zero_q <= 1'b1;
               update_pc_q  <= 1'b1;
               state_q      <= ST_INIT_PC;
            end
            ST_INIT_PC: begin
               // PC init (force_zero high) or PCUPD after WB (force_zero low).
               force_zero_q <= 1'b0;
               update_pc_q  <= 1'b0;
               imem_req_q   <= run;
               state_q      <= ST_FETCH;
            end
            ST_FETCH: begin
               if (imem_req_q) begin
                  // A raised request is held until acknowledged, whatever run does.
                  if (imem_ack) begin
                     imem_req_q <= 1'b0;
                     state_q    <= ST_DECODE;
                  end
               end else begin
                  imem_req_q <= run;
               end
            end
            ST_DECODE: begin
               class_q <= instr_class;
               if (class_is_illegal(instr_class)) begin
                  halted_q  <= 1'b1;
                  illegal_q <= 1'b1;
                  state_q   <= ST_HALT;
               end else if (instr_class == CLASS_SYSTEM) begin
                  halted_q <= 1'b1;
                  state_q  <= ST_HALT;
               end else begin
                  state_q <= ST_EXEC;
               end
            end
            ST_EXEC: begin
               if (class_is_mem(class_q)) begin
                  dmem_req_q <= 1'b1;
                  dmem_we_q  <= (class_q == CLASS_STORE);
                  state_q    <= ST_MEM;
               end else begin
                  rf_we_q <= class_writes_rf(class_q);
                  state_q <= ST_WB;
               end
            end
            ST_MEM: begin
               if (dmem_ack) begin
                  dmem_req_q <= 1'b0;
                  dmem_we_q  <= 1'b0;
                  rf_we_q    <= class_writes_rf(class_q);
                  state_q    <= ST_WB;
               end
            end
            ST_WB: begin
               // PC stays put during WB so pc_plus_4 is stable for the link write.
               rf_we_q     <= 1'b0;
               update_pc_q <= 1'b1;
               state_q     <= ST_INIT_PC;
            end
            ST_HALT: begin
               state_q <= ST_HALT;
            end
            default: begin
               state_q <= ST_INIT;
            end
         endcase
      end
   end

   // Retire on the PCUPD strobe only, not on the PC-initialisation strobe.
   retire_counter #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_retire_counter (
      .clk   (clk),
      .reset (reset),
      .inc   (update_pc_q & ~force_zero_q),
      .count (instret)
   );

   // Acks are only honoured while the matching request is outstanding.
   assign ir_load    = imem_req_q & imem_ack;
   assign imem_req   = imem_req_q;
   assign dmem_req   = dmem_req_q;
   assign dmem_we    = dmem_we_q;
   assign rf_we      = rf_we_q;
   assign force_zero = force_zero_q;
   assign update_pc  = update_pc_q;
   assign halted     = halted_q;
   assign illegal    = illegal_q;
   assign state      = state_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Self-checking bench for cpu_sequencer. Inputs are driven and outputs
// sampled on the falling edge; expected behaviour per instruction comes
// from latency/pulse-count arithmetic derived from the sequencing rules.
module tb_cpu_sequencer;

   localparam int DATA_WIDTH = 32;

   logic                  clk;
   logic                  reset;
   logic                  run;
   logic                  imem_req;
   logic                  imem_ack;
   logic                  ir_load;
   logic [2:0]            instr_class;
   logic                  dmem_req;
   logic                  dmem_we;
   logic                  dmem_ack;
   logic                  rf_we;
   logic                  force_zero;
   logic                  update_pc;
   logic                  halted;
   logic                  illegal;
   logic [DATA_WIDTH-1:0] instret;
   logic [2:0]            state;

   int          n_checks = 0;
   int          n_fail   = 0;
   int unsigned exp_instret = 0;

   cpu_sequencer #(
      .DATA_WIDTH (DATA_WIDTH)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .run         (run),
      .imem_req    (imem_req),
      .imem_ack    (imem_ack),
      .ir_load     (ir_load),
      .instr_class (instr_class),
      .dmem_req    (dmem_req),
      .dmem_we     (dmem_we),
      .dmem_ack    (dmem_ack),
      .rf_we       (rf_we),
      .force_zero  (force_zero),
      .update_pc   (update_pc),
      .halted      (halted),
      .illegal     (illegal),
      .instret     (instret),
      .state       (state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, act, exp);
      end
   endtask

   // Hold reset for two cycles, release, and walk INIT -> INIT_PC -> FETCH.
   task automatic do_reset();
      reset       = 1'b1;
      run         = 1'b1;
      imem_ack    = 1'b0;
      dmem_ack    = 1'b0;
      instr_class = 3'd0;
      repeat (2) @(negedge clk);
      exp_instret = 0;
      check("rst_state", state, 0);
      check("rst_force_zero", force_zero, 1);
      check("rst_update_pc", update_pc, 0);
      check("rst_outputs", {imem_req, dmem_req, dmem_we, rf_we, ir_load}, 0);
      check("rst_status", {halted, illegal}, 0);
      check("rst_instret", instret, 0);
      reset = 1'b0;
      @(negedge clk);
      check("init_pc_state", state, 1);
      check("init_pc_update", update_pc, 1);
      check("init_pc_force_zero", force_zero, 1);
      @(negedge clk);
      check("first_fetch_state", state, 2);
      check("first_fetch_req", imem_req, 1);
      check("first_fetch_flags", {force_zero, update_pc}, 0);
      check("first_fetch_instret", instret, 0);
   endtask

   // One non-halting instruction, starting at a FETCH cycle with imem_req high.
   task automatic run_instr(input logic [2:0] cls, input int idly, input int ddly, input logic next_run);
      int   ireq_n, dreq_n, dwe_n, rfwe_n, rfwe_at, irl_n, upd_at;
      logic is_mem, is_st, is_wr;
      is_mem = (cls == 3'd1) || (cls == 3'd2);
      is_st  = (cls == 3'd2);
      is_wr  = (cls == 3'd0) || (cls == 3'd1) || (cls == 3'd4);
      ireq_n = 0; dreq_n = 0; dwe_n = 0; rfwe_n = 0; rfwe_at = 0; irl_n = 0; upd_at = 0;
      check("fetch_req", imem_req, 1);
      instr_class = cls;
      for (int k = 1; k <= 200 && upd_at == 0; k++) begin
         imem_ack = imem_req ? (ireq_n == idly) : 1'($urandom);
         dmem_ack = dmem_req ? (dreq_n == ddly) : 1'($urandom);
         if (imem_req && ireq_n > 0) run = 1'($urandom);
         #1;
         if (imem_req) ireq_n++;
         if (dmem_req) begin
            dreq_n++;
            if (dmem_we) dwe_n++;
         end
         if (ir_load) irl_n++;
         if (rf_we) begin
            rfwe_n++;
            rfwe_at = k;
         end
         if (update_pc) upd_at = k;
         else @(negedge clk);
      end
      run      = next_run;
      imem_ack = 1'b0;
      dmem_ack = 1'b0;
      if (upd_at != 0) exp_instret++;
      check("upd_latency", upd_at, 5 + idly + (is_mem ? 1 + ddly : 0));
      check("imem_req_cycles", ireq_n, idly + 1);
      check("ir_load_pulses", irl_n, 1);
      check("dmem_req_cycles", dreq_n, is_mem ? ddly + 1 : 0);
      check("dmem_we_cycles", dwe_n, is_st ? ddly + 1 : 0);
      check("rf_we_pulses", rfwe_n, is_wr ? 1 : 0);
      if (is_wr) check("rf_we_slot", rfwe_at, upd_at - 1);
      @(negedge clk);
      check("post_state", state, 2);
      check("post_update_pc", update_pc, 0);
      check("post_instret", instret, exp_instret);
      check("post_next_req", imem_req, next_run);
   endtask

   // FETCH with run low: no request, stray acks ignored; then re-enable run.
   task automatic idle_fetch();
      int n;
      n = $urandom_range(1, 5);
      repeat (n) begin
         @(negedge clk);
         imem_ack = 1'($urandom);
         #1;
         check("idle_req", imem_req, 0);
         check("idle_no_load", ir_load, 0);
         check("idle_state", state, 2);
      end
      imem_ack = 1'b0;
      run      = 1'b1;
      @(negedge clk);
   endtask

   // SYSTEM/ILLEGAL instruction: HALT two cycles after the fetch ack, then nothing moves.
   task automatic run_halt(input logic [2:0] cls, input int idly);
      int ireq_n, halt_at;
      ireq_n = 0; halt_at = 0;
      check("halt_fetch_req", imem_req, 1);
      instr_class = cls;
      for (int k = 1; k <= 50 && halt_at == 0; k++) begin
         imem_ack = imem_req ? (ireq_n == idly) : 1'($urandom);
         #1;
         if (imem_req) ireq_n++;
         if (state == 3'd7) halt_at = k;
         else @(negedge clk);
      end
      imem_ack = 1'b0;
      check("halt_latency", halt_at, idly + 3);
      check("halted", halted, 1);
      check("illegal_flag", illegal, (cls != 3'd5) ? 1 : 0);
      repeat (8) begin
         @(negedge clk);
         run         = 1'b1;
         imem_ack    = 1'($urandom);
         dmem_ack    = 1'($urandom);
         instr_class = 3'($urandom);
         #1;
         check("halt_quiet", {imem_req, dmem_req, rf_we, update_pc, ir_load}, 0);
         check("halt_state", state, 7);
      end
      imem_ack = 1'b0;
      dmem_ack = 1'b0;
      check("halt_sticky", {halted, illegal}, {1'b1, (cls != 3'd5)});
      check("halt_instret", instret, exp_instret);
   endtask

   // Reset arriving while a LOAD waits in MEM must drop dmem_req at once.
   task automatic reset_in_mem();
      logic got;
      got = 1'b0;
      check("memrst_fetch_req", imem_req, 1);
      instr_class = 3'd1;
      imem_ack    = 1'b1;
      dmem_ack    = 1'b0;
      for (int k = 0; k < 20 && !got; k++) begin
         @(negedge clk);
         imem_ack = 1'b0;
         if (dmem_req) got = 1'b1;
      end
      check("memrst_reached_mem", got, 1);
      reset = 1'b1;
      @(negedge clk);
      check("memrst_dmem_req", dmem_req, 0);
      check("memrst_state", state, 0);
      check("memrst_force_zero", force_zero, 1);
      check("memrst_instret", instret, 0);
   endtask

   initial begin
      do_reset();
      run_instr(3'd0, 0, 0, 1'b1);   // ALU, zero-wait
      run_instr(3'd1, 0, 3, 1'b1);   // LOAD, dmem ack 3 cycles late
      run_instr(3'd2, 1, 2, 1'b1);   // STORE
      run_instr(3'd3, 2, 0, 1'b0);   // BRANCH, then run low
      idle_fetch();
      run_instr(3'd4, 0, 0, 1'b1);   // JUMP
      run_halt(3'd6, 0);
      do_reset();
      reset_in_mem();
      do_reset();
      for (int i = 0; i < 40; i++) begin
         if ($urandom_range(0, 9) == 0) begin
            run_halt(3'($urandom_range(5, 7)), $urandom_range(0, 3));
            do_reset();
         end else begin
            logic nr;
            nr = ($urandom_range(0, 3) != 0);
            run_instr(3'($urandom_range(0, 4)), $urandom_range(0, 3), $urandom_range(0, 3), nr);
            if (!nr) idle_fetch();
         end
      end
      run_halt(3'd5, 1);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
